// File: rtl/ia_skew_feeder.sv
// ia_skew_feeder
// Feeds IA rows into the systolic array's row inputs. Each cycle one parallel row
// is registered (stage 0). The optional zero-point offset is added with saturation,
// and padding lanes are zero-filled. The row is then skewed diagonally, so that
// lane i reaches the array i+1 cycles after the row was sampled.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   cfg_load          latch lhs_zp / ia_use_offset (only while idle, no row input)
//   lhs_zp            signed zero-point offset
//   ia_use_offset     add offset to enabled lanes
//   in_row_valid      in_data holds a row this cycle
//   in_is_init        row belongs to the first IA tile (clear accumulator)
//   in_calc_done      row belongs to the final IA tile
//   in_sending_done   last row of the tile
//   in_lane_en        per-lane valid mask, 0 = padding lane
//   in_data           SIZE packed signed elements, lane 0 in the LSBs
//   out_data          skewed, offset elements, lane 0 in the LSBs
//   out_valid/init/last  per-lane flags travelling with the data
//   tile_done         pulse when the tile's last row leaves lane SIZE-1
//   busy              any row still in flight
//   cfg_err           pulse one cycle after a rejected cfg_load
//
// SIZE must be at least 2 and OUT_WIDTH must be greater than DATA_WIDTH.
module ia_skew_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_WIDTH  = 17,
    parameter int SIZE       = 16,
    parameter int REG_WIDTH  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_load,
    input  logic [REG_WIDTH-1:0]       lhs_zp,
    input  logic                       ia_use_offset,
    input  logic                       in_row_valid,
    input  logic                       in_is_init,
    input  logic                       in_calc_done,
    input  logic                       in_sending_done,
    input  logic [SIZE-1:0]            in_lane_en,
    input  logic [SIZE*DATA_WIDTH-1:0] in_data,
    output logic [SIZE*OUT_WIDTH-1:0]  out_data,
    output logic [SIZE-1:0]            out_valid,
    output logic [SIZE-1:0]            out_init,
    output logic [SIZE-1:0]            out_last,
    output logic                       tile_done,
    output logic                       busy,
    output logic                       cfg_err
);

    localparam int SW = REG_WIDTH + 1;
    localparam logic [SW-1:0] SAT_MAX = {{(SW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [SW-1:0] SAT_MIN = ~SAT_MAX;

    logic [REG_WIDTH-1:0] zp_q;
    logic                 use_off_q;
    logic                 cfg_err_q;
    logic                 cfg_ok;

    // Flag chains are shared by all lanes: bit k is the row of age k, and lane i
    // reads age i. Stage k of every lane carries the same row, so busy is just
    // the OR over ages.
    logic [SIZE-1:0] vld_q;
    logic [SIZE-1:0] init_q;
    logic [SIZE-1:0] last_q;
    logic [SIZE-1:0] sd_q;

    logic [OUT_WIDTH-1:0] s0_d [SIZE];
    logic [OUT_WIDTH-1:0] s0_q [SIZE];

    function automatic logic [OUT_WIDTH-1:0] lane_value(
        input logic [DATA_WIDTH-1:0] x,
        input logic [REG_WIDTH-1:0]  zp,
        input logic                  use_off
    );
        logic [SW-1:0] sum;
        if (!use_off) begin
            return {{(OUT_WIDTH-DATA_WIDTH){x[DATA_WIDTH-1]}}, x};
        end
        sum = {{(SW-DATA_WIDTH){x[DATA_WIDTH-1]}}, x} + {zp[REG_WIDTH-1], zp};
        if ($signed(sum) > $signed(SAT_MAX)) begin
            return SAT_MAX[OUT_WIDTH-1:0];
        end else if ($signed(sum) < $signed(SAT_MIN)) begin
            return SAT_MIN[OUT_WIDTH-1:0];
        end
        return sum[OUT_WIDTH-1:0];
    endfunction

    assign busy   = |vld_q;
    assign cfg_ok = cfg_load && !busy && !in_row_valid;

    always_comb begin
        for (int i = 0; i < SIZE; i++) begin
            s0_d[i] = '0;
            if (in_row_valid && in_lane_en[i]) begin
                s0_d[i] = lane_value(in_data[i*DATA_WIDTH +: DATA_WIDTH], zp_q, use_off_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zp_q      <= '0;
            use_off_q <= 1'b0;
            cfg_err_q <= 1'b0;
            vld_q     <= '0;
            init_q    <= '0;
            last_q    <= '0;
            sd_q      <= '0;
            for (int i = 0; i < SIZE; i++) begin
                s0_q[i] <= '0;
            end
        end else begin
            cfg_err_q <= cfg_load && !cfg_ok;
            if (cfg_ok) begin
                zp_q      <= lhs_zp;
                use_off_q <= ia_use_offset;
            end
            vld_q  <= {vld_q[SIZE-2:0], in_row_valid};
            init_q <= {init_q[SIZE-2:0], in_row_valid && in_is_init};
            last_q <= {last_q[SIZE-2:0], in_row_valid && in_calc_done};
            sd_q   <= {sd_q[SIZE-2:0], in_row_valid && in_sending_done};
            for (int i = 0; i < SIZE; i++) begin
                s0_q[i] <= s0_d[i];
            end
        end
    end

    assign tile_done = sd_q[SIZE-1];
    assign cfg_err   = cfg_err_q;

    for (genvar g = 0; g < SIZE; g++) begin : g_lane
        assign out_valid[g] = vld_q[g];
        assign out_init[g]  = init_q[g];
        assign out_last[g]  = last_q[g];

        if (g == 0) begin : g_direct
            assign out_data[0 +: OUT_WIDTH] = s0_q[0];
        end else begin : g_skew
            logic [OUT_WIDTH-1:0] sk_q [g];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k < g; k++) begin
                        sk_q[k] <= '0;
                    end
                end else begin
                    sk_q[0] <= s0_q[g];
                    for (int k = 1; k < g; k++) begin
                        sk_q[k] <= sk_q[k-1];
                    end
                end
            end

            assign out_data[g*OUT_WIDTH +: OUT_WIDTH] = sk_q[g-1];
        end
    end

endmodule

// File: tb/tb_ia_skew_feeder.sv
// Testbench for ia_skew_feeder with SIZE=4, DATA_WIDTH=8, OUT_WIDTH=9.
// Holds a row-age model (expected lane values computed from the offset and
// saturation rules) plus literal checks taken from hand-worked examples.
module tb_ia_skew_feeder;
    localparam int DW = 8;
    localparam int OW = 9;
    localparam int SZ = 4;
    localparam int RW = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic cfg_load;
    logic [RW-1:0] lhs_zp;
    logic ia_use_offset;
    logic in_row_valid;
    logic in_is_init;
    logic in_calc_done;
    logic in_sending_done;
    logic [SZ-1:0] in_lane_en;
    logic [SZ*DW-1:0] in_data;
    logic [SZ*OW-1:0] out_data;
    logic [SZ-1:0] out_valid;
    logic [SZ-1:0] out_init;
    logic [SZ-1:0] out_last;
    logic tile_done;
    logic busy;
    logic cfg_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ia_skew_feeder #(
        .DATA_WIDTH(DW), .OUT_WIDTH(OW), .SIZE(SZ), .REG_WIDTH(RW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .lhs_zp(lhs_zp),
        .ia_use_offset(ia_use_offset), .in_row_valid(in_row_valid),
        .in_is_init(in_is_init), .in_calc_done(in_calc_done),
        .in_sending_done(in_sending_done), .in_lane_en(in_lane_en),
        .in_data(in_data), .out_data(out_data), .out_valid(out_valid),
        .out_init(out_init), .out_last(out_last), .tile_done(tile_done),
        .busy(busy), .cfg_err(cfg_err)
    );

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int lane_out(int i);
        logic [OW-1:0] v;
        v = out_data[i*OW +: OW];
        return int'($signed(v));
    endfunction

    function automatic int lane_val(int x, bit en, bit use_o, int zp);
        longint s;
        if (!en) return 0;
        if (!use_o) return x;
        s = longint'(x) + longint'(zp);
        if (s > 255) s = 255;
        if (s < -256) s = -256;
        return int'(s);
    endfunction

    // Model: index k = row age in cycles since it was sampled.
    bit m_v [SZ];
    bit m_init [SZ];
    bit m_last [SZ];
    bit m_sd [SZ];
    int m_d [SZ][SZ];
    int m_zp;
    bit m_use;
    bit m_err;

    always @(posedge clk or negedge rst_n) begin
        bit b;
        if (!rst_n) begin
            for (int k = 0; k < SZ; k++) begin
                m_v[k] = 0; m_init[k] = 0; m_last[k] = 0; m_sd[k] = 0;
                for (int l = 0; l < SZ; l++) m_d[k][l] = 0;
            end
            m_zp = 0; m_use = 0; m_err = 0;
        end else begin
            b = 0;
            for (int k = 0; k < SZ; k++) b |= m_v[k];
            m_err = cfg_load && (b || in_row_valid);
            for (int k = SZ-1; k > 0; k--) begin
                m_v[k] = m_v[k-1]; m_init[k] = m_init[k-1];
                m_last[k] = m_last[k-1]; m_sd[k] = m_sd[k-1];
                for (int l = 0; l < SZ; l++) m_d[k][l] = m_d[k-1][l];
            end
            m_v[0]    = in_row_valid;
            m_init[0] = in_row_valid && in_is_init;
            m_last[0] = in_row_valid && in_calc_done;
            m_sd[0]   = in_row_valid && in_sending_done;
            for (int l = 0; l < SZ; l++) begin
                m_d[0][l] = in_row_valid ?
                    lane_val(int'($signed(in_data[l*DW +: DW])), in_lane_en[l], m_use, m_zp) : 0;
            end
            if (cfg_load && !b && !in_row_valid) begin
                m_zp  = int'($signed(lhs_zp));
                m_use = ia_use_offset;
            end
        end
    end

    always @(negedge clk) begin
        bit eb;
        if (rst_n) begin
            eb = 0;
            for (int i = 0; i < SZ; i++) begin
                eb |= m_v[i];
                chk($sformatf("data_l%0d", i), lane_out(i), m_d[i][i]);
                chk($sformatf("valid_l%0d", i), int'(out_valid[i]), int'(m_v[i]));
                if (m_v[i]) begin
                    chk($sformatf("init_l%0d", i), int'(out_init[i]), int'(m_init[i]));
                    chk($sformatf("last_l%0d", i), int'(out_last[i]), int'(m_last[i]));
                end
            end
            chk("tile_done", int'(tile_done), int'(m_sd[SZ-1]));
            chk("busy", int'(busy), int'(eb));
            chk("cfg_err", int'(cfg_err), int'(m_err));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_idle();
        cfg_load = 0; in_row_valid = 0; in_is_init = 0; in_calc_done = 0;
        in_sending_done = 0; in_lane_en = '0; in_data = '0;
    endtask

    task automatic set_row(input logic [SZ*DW-1:0] d, input logic [SZ-1:0] en,
                           input bit init, input bit last, input bit sd);
        cfg_load = 0; in_row_valid = 1; in_is_init = init; in_calc_done = last;
        in_sending_done = sd; in_lane_en = en; in_data = d;
    endtask

    task automatic do_cfg(input int zp, input bit use_o);
        set_idle();
        cfg_load = 1; lhs_zp = zp; ia_use_offset = use_o;
        step();
        cfg_load = 0;
    endtask

    // One row, idle afterwards; lane i is read i+1 cycles later.
    task automatic row_lit(input string nm, input logic [SZ*DW-1:0] d, input logic [SZ-1:0] en,
                           input int e0, input int e1, input int e2, input int e3);
        int e [SZ];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        set_row(d, en, 0, 0, 0);
        for (int i = 0; i < SZ; i++) begin
            step();
            set_idle();
            chk($sformatf("%s_l%0d", nm, i), lane_out(i), e[i]);
            chk($sformatf("%s_v%0d", nm, i), int'(out_valid[i]), 1);
        end
        step();
    endtask

    initial begin
        int cnt;
        rst_n = 0; lhs_zp = '0; ia_use_offset = 0;
        set_idle();
        step(); step();
        rst_n = 1;
        step();
        chk("rst_data", int'(out_data == '0), 1);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_tile_done", int'(tile_done), 0);
        chk("rst_cfg_err", int'(cfg_err), 0);

        // Back-to-back rows, no offset
        set_row({8'd4, 8'd3, 8'd2, 8'd1}, 4'hF, 0, 0, 0);
        step(); chk("tp1_l0_r0", lane_out(0), 1);
        set_row({8'd8, 8'd7, 8'd6, 8'd5}, 4'hF, 0, 0, 0);
        step(); chk("tp1_l0_r1", lane_out(0), 5);
        set_idle();
        step();
        step(); chk("tp1_l3_r0", lane_out(3), 4);
        step(); chk("tp1_l3_r1", lane_out(3), 8); chk("tp1_busy5", int'(busy), 1);
        step(); chk("tp1_busy6", int'(busy), 0);

        do_cfg(-128, 1);
        row_lit("zp_m128", {8'd5, 8'd0, 8'h80, 8'd127}, 4'hF, -1, -256, -128, -123);
        do_cfg(300, 1);
        row_lit("sat_hi", {8'd0, 8'd0, 8'd0, 8'd100}, 4'hF, 255, 255, 255, 255);
        do_cfg(-300, 1);
        row_lit("sat_lo", {8'd0, 8'd0, 8'd0, 8'h9C}, 4'hF, -256, -256, -256, -256);
        do_cfg(10, 1);
        row_lit("mask", {8'd1, 8'd1, 8'd1, 8'd1}, 4'b0011, 11, 11, 0, 0);

        // Tile of 3 rows, sending_done on the third
        set_row({8'd3, 8'd2, 8'd1, 8'd0}, 4'hF, 1, 0, 0); step();
        set_row({8'd7, 8'd6, 8'd5, 8'd4}, 4'hF, 1, 0, 0); step();
        set_row({8'd11, 8'd10, 8'd9, 8'd8}, 4'hF, 1, 1, 1); step();
        set_idle();
        step(); chk("tile_c4", int'(tile_done), 0);
        step(); chk("tile_c5", int'(tile_done), 0);
        step(); chk("tile_c6", int'(tile_done), 1);
        chk("tile_c6_v3", int'(out_valid[3]), 1);
        chk("tile_c6_last3", int'(out_last[3]), 1);
        step(); chk("tile_c7", int'(tile_done), 0);
        step();

        // cfg_load while busy is rejected, old zp (10) stays
        set_row({8'd1, 8'd1, 8'd1, 8'd1}, 4'hF, 0, 0, 0); step();
        set_idle(); cfg_load = 1; lhs_zp = 50; ia_use_offset = 1;
        step(); cfg_load = 0;
        chk("cfg_err_pulse", int'(cfg_err), 1);
        step(); chk("cfg_err_clear", int'(cfg_err), 0);
        for (int i = 0; i < SZ; i++) step();
        set_row({8'd1, 8'd1, 8'd1, 8'd1}, 4'hF, 0, 0, 0); step();
        set_idle();
        chk("cfg_old_zp", lane_out(0), 11);
        step();

        // Reset mid-tile
        set_row({8'd1, 8'd2, 8'd3, 8'd4}, 4'hF, 0, 0, 0); step();
        set_row({8'd5, 8'd6, 8'd7, 8'd8}, 4'hF, 0, 1, 1); step();
        set_idle();
        #2 rst_n = 0;
        #1;
        chk("midrst_data", int'(out_data == '0), 1);
        chk("midrst_valid", int'(out_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        step(); step();
        rst_n = 1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (tile_done) cnt++;
        end
        chk("midrst_no_tile_done", cnt, 0);

        // Randomized traffic with config attempts
        for (int n = 0; n < 400; n++) begin
            set_idle();
            if ($urandom_range(0, 9) == 0) begin
                cfg_load = 1;
                lhs_zp = $urandom_range(0, 1200) - 600;
                ia_use_offset = 1'($urandom_range(0, 1));
                in_row_valid = 1'($urandom_range(0, 1));
                in_data = $urandom();
                in_lane_en = 4'($urandom());
            end else if ($urandom_range(0, 9) < 7) begin
                set_row($urandom(), 4'($urandom()), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            step();
        end
        set_idle();
        for (int i = 0; i < SZ + 2; i++) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ia_skew_feeder.md
Name: ia_skew_feeder

Overview:
- Sits between the IA loader and the systolic array's row inputs.
- Takes one parallel IA row per cycle and applies the optional zero-point offset per lane.
- Zero-fills masked (boundary) lanes.
- Skews the row diagonally so that lane i reaches the array i cycles after lane 0; the per-lane init/last flags travel with the data.

Parameters:
- DATA_WIDTH, 16, width of each incoming IA element (signed).
- OUT_WIDTH, 17, width of each outgoing element after offset (signed, saturated).
- SIZE, 16, number of lanes (systolic array row count).
- REG_WIDTH, 32, width of configuration registers.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- cfg_load  input  1  latch lhs_zp / ia_use_offset.
- lhs_zp  input  REG_WIDTH  signed zero-point offset.
- ia_use_offset  input  1  1 = add the offset to enabled lanes.
- in_row_valid  input  1  in_data holds a valid row this cycle.
- in_is_init  input  1  row belongs to the first IA tile of the accumulation (clear the accumulator).
- in_calc_done  input  1  row belongs to the final IA tile (partial sum is final).
- in_sending_done  input  1  this row is the last row of the tile.
- in_lane_en  input  SIZE  per-lane column-valid mask; 0 = padding lane.
- in_data  input  SIZE x DATA_WIDTH  signed row data.
- out_data  output  SIZE x OUT_WIDTH  skewed data, lane i.
- out_valid  output  SIZE  per-lane valid.
- out_init  output  SIZE  per-lane init flag.
- out_last  output  SIZE  per-lane calc_done flag.
- tile_done  output  1  one-cycle pulse when the last row leaves lane SIZE-1.
- busy  output  1  any row still in flight.
- cfg_err  output  1  one-cycle pulse: cfg_load rejected.

Behaviour:
- Reset:
  - All out_data = 0; out_valid, out_init, out_last, tile_done, busy and cfg_err = 0.
  - Configuration registers clear to 0, so the offset is disabled.
  - All skew stages clear to 0.
  - Reset asserted mid-operation discards every in-flight row; no tile_done is issued for it.
- Configuration:
  - cfg_load with busy=0 and in_row_valid=0 latches lhs_zp and ia_use_offset at the clock edge.
  - cfg_load with busy=1 or in_row_valid=1 is ignored and cfg_err pulses the next cycle.
- Stage 0 (registered, 1 cycle), per lane i, sampled when in_row_valid=1:
  - If in_lane_en[i]=0: value = 0.
  - Else if use_offset=1: value = sat(in_data[i] + zp).
  - Else: value = sign-extend(in_data[i]).
  - The sum is computed at REG_WIDTH+1 bits and saturated to the OUT_WIDTH signed range [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - When in_row_valid=0, stage 0 captures data = 0 and valid = 0.
- Skew:
  - Lane i passes through i additional register stages.
  - Total latency from input to out_* lane i is i+1 cycles.
  - Each stage carries {data, valid, init, last}.
  - A lane with valid=0 always presents out_data=0.
- Throughput: one row per cycle, back-to-back, with no stalls. The block has no backpressure and the downstream array always accepts.
- tile_done:
  - in_sending_done is sampled with in_row_valid=1 and is delayed SIZE cycles.
  - tile_done pulses in the same cycle that out_valid[SIZE-1] shows that row.
  - in_sending_done with in_row_valid=0 is ignored.
- busy:
  - busy = OR of all valid bits in every stage, including stage 0.
  - busy goes high the cycle after the first valid input and low the cycle after lane SIZE-1 emits the last valid row.
- Flags: in_is_init and in_calc_done are copied per row into every lane unchanged. Masked lanes still carry valid=1 and the flags, with data=0.
- Simultaneous new row input and an in-flight drain are legal; the pipelines are independent.

Test Plan:
- SIZE=4, zp=0, use_offset=0. Rows R0={1,2,3,4} and R1={5,6,7,8} on back-to-back cycles.
  - Lane0 shows 1 at cycle 1 and 5 at cycle 2.
  - Lane3 shows 4 at cycle 4 and 8 at cycle 5.
  - busy stays high through cycle 5.
- use_offset=1, zp=-128, DATA_WIDTH=8, OUT_WIDTH=9. Input {127,-128,0,5} gives lane outputs {-1,-256,-128,-123}.
- Saturation: OUT_WIDTH=9, zp=300, input 100. Result is 255; with zp=-300, input -100, the result is -256.
- in_lane_en=4'b0011 with use_offset=1, zp=10, input {1,1,1,1}.
  - Lanes 0 and 1 output 11.
  - Lanes 2 and 3 output 0 with valid=1.
- Tile of 3 rows with in_sending_done on row 2 at cycle 2:
  - tile_done pulses at cycle 6 (SIZE=4), coincident with lane3 row 2.
  - init/last flags match the inputs on every lane.
- cfg_load while busy=1 causes a cfg_err pulse and the old zp stays in use. Asserting rst_n=0 mid-tile drops all outputs to 0 immediately and no tile_done is issued.
